vending_machine: RTL and testbench
==================================

Name: vending_machine

Overview:
- Single-product coin-accepting controller; item price is 15 units.
- Accepts 5-unit and 10-unit coin pulses and accumulates credit in a 4-state Moore FSM.
- Asserts a one-cycle dispense strobe once credit reaches or exceeds the price.
- Sits between coin-detector logic (one-cycle pulses, synchronous to clk) and the dispense actuator; exposes its state for debug and monitoring.

Parameters:
- None. Price (15) and coin values (5, 10) are fixed constants from the shared package.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; forces state to S0
- coin_5  input  1  high for one clk cycle = one 5-unit coin inserted
- coin_10  input  1  high for one clk cycle = one 10-unit coin inserted
- dispense  output  1  high for exactly the cycle(s) the FSM is in S15; registered-state decode, no input combinational path
- current_state  output  2  current FSM state encoding (S0=00, S5=01, S10=10, S15=11)

Behaviour:
- Reset: on a rising edge with reset=1, state becomes S0, so dispense=0 and current_state=00. Reset overrides all coin inputs and is honoured mid-transaction; accumulated credit is lost.
- Coin inputs are sampled on each rising edge. A level held high for N cycles counts as N coins.
- If coin_5 and coin_10 are both high in the same cycle, coin_10 takes priority and coin_5 is ignored.
- Transitions (next state per edge, reset=0):
  - S0: coin_10 -> S10; coin_5 -> S5; none -> S0
  - S5: coin_10 -> S15; coin_5 -> S10; none -> S5
  - S10: coin_10 -> S15 (overpay of 5 forfeited, no change returned); coin_5 -> S15; none -> S10
  - S15 (dispensing): coin_10 -> S10; coin_5 -> S5; none -> S0. A coin arriving in the dispense cycle starts a new purchase.
- Outputs (Moore):
  - dispense = (state == S15)
  - current_state = state register
- Latency: dispense goes high on the clock edge that samples the completing coin, i.e. one cycle after the coin pulse is presented. It lasts exactly one cycle unless further completing coins keep the FSM in S15. Dispense cannot be re-asserted without new coins.
- No timeout: credit is held indefinitely while idle.
- Illegal or unreachable encodings are not applicable (all 4 codes are used). The default branch of the next-state decode goes to S0.

Decomposition:
- Package vending_machine_pkg:
  - state enum (S0, S5, S10, S15, 2-bit)
  - constants PRICE=15, COIN_5_VAL=5, COIN_10_VAL=10
- No sub-module. A single module holds the state register, next-state logic and output decode.

Test Plan:
1. Reset for one edge with coins 0 -> current_state=00, dispense=0; hold 20 cycles with no coins -> stays 00.
2. coin_5 pulse, 2 idle cycles, then coin_10 pulse -> state 01 then 11 with dispense=1 for exactly one cycle, then 00.
3. Three coin_5 pulses spaced 5 cycles apart -> 01, 10, 11 (dispense=1 for one cycle), then 00.
4. coin_10, coin_10 -> 10, then 11 with dispense; next cycle 00 (overpay forfeited).
5. Enter S15, then coin_10 in the dispense cycle -> next state 10, dispense=0; then coin_5 -> 11, dispense=1.
6. Both coins high in S0 -> 10 (coin_10 priority). Reset asserted while in S10 -> 00 on the next edge even with coin_5 high.

Source files
------------

// File: rtl/vending_machine_pkg.sv
// vending_machine_pkg: shared state encoding, coin/price constants and credit-based next-state helper
package vending_machine_pkg;
  typedef enum logic [1:0] {S0 = 2'b00, S5 = 2'b01, S10 = 2'b10, S15 = 2'b11} state_t;
  localparam int PRICE = 15;
  localparam int COIN_5_VAL = 5;
  localparam int COIN_10_VAL = 10;
  // S15 is the dispense cycle, so its credit is already spent; coin_10 wins over coin_5
  function automatic state_t next_state(state_t s, logic c5, logic c10);
    int base;
    int sum;
    base = (s == S15) ? 0 : int'(s) * COIN_5_VAL;
    sum = base + (c10 ? COIN_10_VAL : c5 ? COIN_5_VAL : 0);
    return (sum >= PRICE) ? S15 : state_t'(2'(sum / COIN_5_VAL));
  endfunction
endpackage

// File: rtl/vending_machine.sv
// vending_machine: Moore coin-credit FSM with one-cycle dispense strobe at price 15
module vending_machine
  import vending_machine_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic       dispense,
  output logic [1:0] current_state
);
  state_t state, next;
  always_ff @(posedge clk)
    state <= reset ? S0 : next;
  always_comb begin
    next = S0;
    next = next_state(state, coin_5, coin_10);
  end
  assign dispense = (state == S15);
  assign current_state = state;
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed vectors with hand-computed states for the vending FSM
module tb_vending_machine;
  logic clk = 0, reset = 1, coin_5 = 0, coin_10 = 0;
  logic dispense;
  logic [1:0] current_state;
  int errors = 0, checks = 0;

  vending_machine dut (
    .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10),
    .dispense(dispense), .current_state(current_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {dispense,state}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [1:0] s);
    check(tag, {dispense, current_state}, {s == 2'b11, s});
  endtask

  task automatic cyc(input logic c5, input logic c10);
    coin_5 = c5;
    coin_10 = c10;
    @(posedge clk);
    #1;
    coin_5 = 0;
    coin_10 = 0;
  endtask

  initial begin
    // reset and idle hold
    reset = 1;
    cyc(0, 0);
    expect_state("reset", 2'b00);
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0);
      expect_state("idle_hold", 2'b00);
    end
    // 5 then 10
    cyc(1, 0); expect_state("t2_c5", 2'b01);
    cyc(0, 0); expect_state("t2_wait1", 2'b01);
    cyc(0, 0); expect_state("t2_wait2", 2'b01);
    cyc(0, 1); expect_state("t2_c10_disp", 2'b11);
    cyc(0, 0); expect_state("t2_after", 2'b00);
    // three spaced nickels
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0);
      expect_state("t3_coin", 2'(k));
      for (int j = 0; j < 4; j++) begin
        cyc(0, 0);
        expect_state("t3_gap", (k == 3) ? 2'b00 : 2'(k));
      end
    end
    // 10 + 10, overpay forfeited
    cyc(0, 1); expect_state("t4_c10", 2'b10);
    cyc(0, 1); expect_state("t4_c10_disp", 2'b11);
    cyc(0, 0); expect_state("t4_after", 2'b00);
    // coins arriving in the dispense cycle
    cyc(0, 1); expect_state("t5_c10", 2'b10);
    cyc(1, 0); expect_state("t5_c5_disp", 2'b11);
    cyc(0, 1); expect_state("t5_s15_c10", 2'b10);
    cyc(1, 0); expect_state("t5_c5_disp2", 2'b11);
    cyc(1, 0); expect_state("t5_s15_c5", 2'b01);
    cyc(0, 0); expect_state("t5_hold", 2'b01);
    cyc(1, 0); expect_state("t5_c5", 2'b10);
    cyc(1, 0); expect_state("t5_disp3", 2'b11);
    cyc(0, 0); expect_state("t5_after", 2'b00);
    // held level counts per cycle
    cyc(1, 0); expect_state("hold_c5_1", 2'b01);
    cyc(1, 0); expect_state("hold_c5_2", 2'b10);
    cyc(1, 0); expect_state("hold_c5_3", 2'b11);
    cyc(0, 0); expect_state("hold_after", 2'b00);
    // priority and mid-transaction reset
    cyc(1, 1); expect_state("t6_both", 2'b10);
    reset = 1;
    cyc(1, 0); expect_state("t6_reset", 2'b00);
    reset = 0;
    cyc(0, 0); expect_state("t6_post_reset", 2'b00);
    cyc(0, 1); expect_state("t6_c10", 2'b10);
    cyc(1, 1); expect_state("t6_both_disp", 2'b11);
    cyc(0, 0); expect_state("t6_after", 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
